// File: rtl/conv_lb_feeder.sv
// Ingress driver for the convolution line buffer: turns a sof/eol framed pixel
// stream into registered push/pop strobes, learns line width from line 0 and flags framing errors.
module conv_lb_feeder #(
    parameter int PIXEL_W     = 8,
    parameter int IMAGE_MAX_W = 16,
    parameter int IMAGE_MAX_H = 8,
    localparam int COL_W      = $clog2(IMAGE_MAX_W),
    localparam int LINE_W     = $clog2(IMAGE_MAX_H)
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               in_vld_i,
    output logic               in_rdy_o,
    input  logic [PIXEL_W-1:0] in_dat_i,
    input  logic               in_sof_i,
    input  logic               in_eol_i,
    input  logic               stall_i,
    output logic               push_o,
    output logic               pop_o,
    output logic [PIXEL_W-1:0] dat_o,
    output logic               sof_o,
    output logic               eol_o,
    output logic [COL_W:0]     width_o,
    output logic [LINE_W-1:0]  line_o,
    output logic               err_o
);

    typedef enum logic [1:0] {IDLE, LINE0, LINEN, ERR} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [COL_W:0]     width_q, width_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               err_q, err_d;
    logic [PIXEL_W-1:0] dat_q, dat_d;
    logic               push_q, push_d, pop_q, pop_d, sof_q, sof_d, eol_q, eol_d;

    logic              accept, at_max, at_last;
    logic [LINE_W-1:0] line_inc;

    assign in_rdy_o = ~stall_i;
    assign accept   = in_vld_i & ~stall_i;
    assign at_max   = (col_q == COL_W'(IMAGE_MAX_W - 1));
    assign at_last  = ({1'b0, col_q} == width_q - (COL_W+1)'(1));
    assign line_inc = (line_q == LINE_W'(IMAGE_MAX_H - 1)) ? line_q : line_q + LINE_W'(1);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        width_d = width_q;
        line_d  = line_q;
        err_d   = err_q;
        dat_d   = dat_q;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        if (accept) begin
            if (in_sof_i) begin
                push_d = 1'b1;
                sof_d  = 1'b1;
                dat_d  = in_dat_i;
                err_d  = 1'b0;
                if (in_eol_i) begin
                    // a single-pixel line 0 is complete on the sof pixel itself
                    eol_d   = 1'b1;
                    width_d = (COL_W+1)'(1);
                    line_d  = LINE_W'(1);
                    col_d   = '0;
                    state_d = LINEN;
                end else begin
                    line_d  = '0;
                    col_d   = COL_W'(1);
                    state_d = LINE0;
                end
            end else begin
                case (state_q)
                    LINE0: begin
                        if (in_eol_i) begin
                            push_d  = 1'b1;
                            eol_d   = 1'b1;
                            dat_d   = in_dat_i;
                            width_d = {1'b0, col_q} + (COL_W+1)'(1);
                            col_d   = '0;
                            line_d  = line_inc;
                            state_d = LINEN;
                        end else if (at_max) begin
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else begin
                            push_d = 1'b1;
                            dat_d  = in_dat_i;
                            col_d  = col_q + COL_W'(1);
                        end
                    end
                    LINEN: begin
                        if (in_eol_i && at_last) begin
                            push_d = 1'b1;
                            pop_d  = 1'b1;
                            eol_d  = 1'b1;
                            dat_d  = in_dat_i;
                            col_d  = '0;
                            line_d = line_inc;
                        end else if (in_eol_i || at_last) begin
                            // early or late eol: drop the pixel and wait for sof
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else begin
                            push_d = 1'b1;
                            pop_d  = 1'b1;
                            dat_d  = in_dat_i;
                            col_d  = col_q + COL_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            col_q   <= '0;
            width_q <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            width_q <= width_d;
            line_q  <= line_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign push_o  = push_q;
    assign pop_o   = pop_q;
    assign sof_o   = sof_q;
    assign eol_o   = eol_q;
    assign dat_o   = dat_q;
    assign width_o = width_q;
    assign line_o  = line_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_conv_lb_feeder.sv
// Directed bench for conv_lb_feeder with IMAGE_MAX_W=16, IMAGE_MAX_H=8, 8-bit pixels.
module tb_conv_lb_feeder;

    logic       clk, arst;
    logic       in_vld_i, in_rdy_o, in_sof_i, in_eol_i, stall_i;
    logic [7:0] in_dat_i, dat_o;
    logic       push_o, pop_o, sof_o, eol_o, err_o;
    logic [4:0] width_o;
    logic [2:0] line_o;

    int n_chk  = 0;
    int n_pass = 0;

    conv_lb_feeder #(.PIXEL_W(8), .IMAGE_MAX_W(16), .IMAGE_MAX_H(8)) dut (
        .clk(clk), .arst(arst), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
        .in_dat_i(in_dat_i), .in_sof_i(in_sof_i), .in_eol_i(in_eol_i),
        .stall_i(stall_i), .push_o(push_o), .pop_o(pop_o), .dat_o(dat_o),
        .sof_o(sof_o), .eol_o(eol_o), .width_o(width_o), .line_o(line_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one cycle of inputs; returns at the next falling edge with the registered result visible
    task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d, input logic st);
        in_vld_i = v; in_sof_i = s; in_eol_i = e; in_dat_i = d; stall_i = st;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [20:0] got;
        arst = 1'b1;
        in_vld_i = 0; in_sof_i = 0; in_eol_i = 0; in_dat_i = 8'h00; stall_i = 0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        drive(0, 0, 0, 8'h00, 0);
        got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o, width_o, line_o};
        n_chk++;
        if (got !== 21'h0) $display("FAIL reset_outputs: got %h exp 0", got); else n_pass++;
        n_chk++;
        if (in_rdy_o !== 1'b1) $display("FAIL reset_rdy: got %b exp 1", in_rdy_o); else n_pass++;
    endtask

    task automatic test_frame();
        logic [12:0] got, exp;
        logic [7:0]  d;
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 4; c++) begin
                d = 8'(l * 16 + c + 1);
                in_vld_i = 1; in_sof_i = (l == 0 && c == 0); in_eol_i = (c == 3); in_dat_i = d; stall_i = 0;
                if (l == 0 && c == 0) begin
                    #1;
                    n_chk++;
                    if (push_o !== 1'b0) $display("FAIL frame_lag: push_o got %b exp 0 before edge", push_o); else n_pass++;
                end
                @(negedge clk);
                got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
                exp = {1'b1, 1'(l > 0), 1'(l == 0 && c == 0), 1'(c == 3), 1'b0, d};
                n_chk++;
                if (got !== exp) $display("FAIL frame_px l%0d c%0d: got %h exp %h", l, c, got, exp); else n_pass++;
            end
            n_chk++;
            if (line_o !== 3'(l + 1)) $display("FAIL frame_line%0d: got %0d exp %0d", l, line_o, l + 1); else n_pass++;
        end
        drive(0, 0, 0, 8'hFF, 0);
        got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
        n_chk++;
        if (got !== {5'b00000, 8'h24}) $display("FAIL frame_idle: got %h exp %h", got, {5'b00000, 8'h24}); else n_pass++;
        n_chk++;
        if (width_o !== 5'd4) $display("FAIL frame_width: got %0d exp 4", width_o); else n_pass++;
        n_chk++;
        if (line_o !== 3'd3) $display("FAIL frame_line_end: got %0d exp 3", line_o); else n_pass++;
    endtask

    task automatic test_early_eol();
        logic [12:0] got, exp;
        for (int c = 0; c < 4; c++) drive(1, c == 0, c == 3, 8'(8'hA0 + c), 0);
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 0, 8'(8'hB0 + c), 0);
            got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
            exp = {5'b11000, 8'(8'hB0 + c)};
            n_chk++;
            if (got !== exp) $display("FAIL early_px c%0d: got %h exp %h", c, got, exp); else n_pass++;
        end
        drive(1, 0, 1, 8'hB2, 0);
        got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
        n_chk++;
        if (got !== {5'b00001, 8'hB1}) $display("FAIL early_err: got %h exp %h", got, {5'b00001, 8'hB1}); else n_pass++;
        drive(1, 0, 0, 8'hB3, 0);
        got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
        n_chk++;
        if (got !== {5'b00001, 8'hB1}) $display("FAIL early_drop: got %h exp %h", got, {5'b00001, 8'hB1}); else n_pass++;
        drive(1, 1, 0, 8'hC0, 0);
        got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
        n_chk++;
        if (got !== {5'b10100, 8'hC0}) $display("FAIL early_sof_clear: got %h exp %h", got, {5'b10100, 8'hC0}); else n_pass++;
    endtask

    task automatic test_overflow_late();
        logic [12:0] got;
        int pushes = 0;
        for (int i = 0; i < 15; i++) begin
            drive(1, i == 0, 0, 8'(8'h10 + i), 0);
            if (push_o === 1'b1) pushes++;
        end
        n_chk++;
        if (pushes != 15) $display("FAIL ovf_pushes: got %0d exp 15", pushes); else n_pass++;
        drive(1, 0, 0, 8'h1F, 0);
        got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
        n_chk++;
        if (got !== {5'b00001, 8'h1E}) $display("FAIL ovf_err: got %h exp %h", got, {5'b00001, 8'h1E}); else n_pass++;
        for (int c = 0; c < 4; c++) drive(1, c == 0, c == 3, 8'(8'h40 + c), 0);
        n_chk++;
        if (width_o !== 5'd4) $display("FAIL late_width: got %0d exp 4", width_o); else n_pass++;
        for (int c = 0; c < 3; c++) drive(1, 0, 0, 8'(8'h50 + c), 0);
        n_chk++;
        if ({push_o, pop_o, dat_o} !== {2'b11, 8'h52}) $display("FAIL late_px: got %h exp %h", {push_o, pop_o, dat_o}, {2'b11, 8'h52}); else n_pass++;
        drive(1, 0, 0, 8'h53, 0);
        got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
        n_chk++;
        if (got !== {5'b00001, 8'h52}) $display("FAIL late_err: got %h exp %h", got, {5'b00001, 8'h52}); else n_pass++;
        drive(1, 0, 1, 8'h54, 0);
        got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
        n_chk++;
        if (got !== {5'b00001, 8'h52}) $display("FAIL late_5th: got %h exp %h", got, {5'b00001, 8'h52}); else n_pass++;
    endtask

    task automatic test_one_px();
        logic [12:0] got, exp;
        int el;
        drive(1, 1, 1, 8'h55, 0);
        got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
        n_chk++;
        if (got !== {5'b10110, 8'h55}) $display("FAIL onepx_sof: got %h exp %h", got, {5'b10110, 8'h55}); else n_pass++;
        n_chk++;
        if ({width_o, line_o} !== {5'd1, 3'd1}) $display("FAIL onepx_wl: got %h exp %h", {width_o, line_o}, {5'd1, 3'd1}); else n_pass++;
        for (int k = 0; k < 9; k++) begin
            drive(1, 0, 1, 8'(8'h60 + k), 0);
            got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
            exp = {5'b11010, 8'(8'h60 + k)};
            el  = (k + 2 > 7) ? 7 : k + 2;
            n_chk++;
            if (got !== exp || line_o !== 3'(el))
                $display("FAIL onepx_line k%0d: got %h line %0d exp %h line %0d", k, got, line_o, exp, el);
            else n_pass++;
        end
        n_chk++;
        if (width_o !== 5'd1) $display("FAIL onepx_width: got %0d exp 1", width_o); else n_pass++;
    endtask

    task automatic test_stall();
        logic [12:0] got, exp;
        logic [7:0]  d, prev;
        int pushes = 0;
        drive(1, 1, 0, 8'h80, 0);
        if (push_o === 1'b1) pushes++;
        prev = 8'h80;
        for (int k = 0; k < 7; k++) begin
            d = 8'(8'h81 + k);
            in_vld_i = 1; in_sof_i = 0; in_eol_i = (k == 2 || k == 6); in_dat_i = d; stall_i = 1;
            #1;
            n_chk++;
            if (in_rdy_o !== 1'b0) $display("FAIL stall_rdy0 k%0d: got %b exp 0", k, in_rdy_o); else n_pass++;
            @(negedge clk);
            if (push_o === 1'b1) pushes++;
            got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
            n_chk++;
            if (got !== {5'b00000, prev}) $display("FAIL stall_hold k%0d: got %h exp %h", k, got, {5'b00000, prev}); else n_pass++;
            stall_i = 0;
            #1;
            n_chk++;
            if (in_rdy_o !== 1'b1) $display("FAIL stall_rdy1 k%0d: got %b exp 1", k, in_rdy_o); else n_pass++;
            @(negedge clk);
            if (push_o === 1'b1) pushes++;
            got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
            exp = {1'b1, 1'(k >= 3), 1'b0, 1'(k == 2 || k == 6), 1'b0, d};
            n_chk++;
            if (got !== exp) $display("FAIL stall_push k%0d: got %h exp %h", k, got, exp); else n_pass++;
            prev = d;
        end
        n_chk++;
        if (pushes != 8) $display("FAIL stall_count: got %0d exp 8", pushes); else n_pass++;
    endtask

    task automatic test_arst_mid();
        logic [20:0] all;
        logic [12:0] got, exp;
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 4; c++) drive(1, l == 0 && c == 0, c == 3, 8'(8'hA0 + l * 4 + c), 0);
        drive(1, 0, 0, 8'hA8, 0);
        drive(1, 0, 0, 8'hA9, 0);
        in_vld_i = 0;
        #2 arst = 1'b1;
        #1;
        all = {push_o, pop_o, sof_o, eol_o, err_o, dat_o, width_o, line_o};
        n_chk++;
        if (all !== 21'h0) $display("FAIL arst_async: got %h exp 0", all); else n_pass++;
        @(negedge clk);
        all = {push_o, pop_o, sof_o, eol_o, err_o, dat_o, width_o, line_o};
        n_chk++;
        if (all !== 21'h0) $display("FAIL arst_edge: got %h exp 0", all); else n_pass++;
        arst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, k == 1, 8'(8'hEE + k), 0);
            got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
            n_chk++;
            if (got !== 13'h0) $display("FAIL arst_nosof k%0d: got %h exp 0", k, got); else n_pass++;
        end
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 3; c++) begin
                drive(1, l == 0 && c == 0, c == 2, 8'(8'hB0 + l * 3 + c), 0);
                got = {push_o, pop_o, sof_o, eol_o, err_o, dat_o};
                exp = {1'b1, 1'(l > 0), 1'(l == 0 && c == 0), 1'(c == 2), 1'b0, 8'(8'hB0 + l * 3 + c)};
                n_chk++;
                if (got !== exp) $display("FAIL arst_newframe l%0d c%0d: got %h exp %h", l, c, got, exp); else n_pass++;
            end
        n_chk++;
        if ({width_o, line_o, err_o} !== {5'd3, 3'd2, 1'b0})
            $display("FAIL arst_final: got %h exp %h", {width_o, line_o, err_o}, {5'd3, 3'd2, 1'b0});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_early_eol();
        test_overflow_late();
        test_one_px();
        test_stall();
        test_arst_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
